// File: rtl/seq_left_shifter.sv
// ============================================================================
//  Module      : seq_left_shifter
//  Description : Multi-cycle left shifter (SLL / RLC through carry), one bit
//                position per clock under a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_left_shifter #(
    parameter int WORD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               operation,
    input  logic [3:0]               status_old,
    input  logic [$clog2(WORD)-1:0]  shift,
    input  logic [WORD-1:0]          in,
    output logic                     busy,
    output logic                     done,
    output logic [WORD-1:0]          out,
    output logic [3:0]               status_new
);

    localparam int         c_CNT_W = $clog2(WORD);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WORD-1:0]    r_acc;
    logic               r_carry;
    logic               r_v;
    logic               r_rlc;

    logic               w_do_step;
    logic               w_last;
    logic [WORD-1:0]    w_next_acc;
    logic               w_next_c;

    // A zero count still spends one SHIFT cycle (no step) so that SLL/RLC
    // latency is max(shift,1)+1 regardless of the count.
    always_comb begin
        w_do_step  = (r_count != '0);
        w_last     = (r_count == '0) || (r_count == c_CNT_W'(1));
        w_next_acc = r_acc;
        w_next_c   = r_carry;
        if (w_do_step) begin
            w_next_acc = {r_acc[WORD-2:0], (r_rlc ? r_carry : 1'b0)};
            w_next_c   = r_acc[WORD-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_v        <= 1'b0;
            r_rlc      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out        <= '0;
            status_new <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_acc   <= in;
                        r_carry <= status_old[0];
                        r_v     <= status_old[3];
                        r_rlc   <= operation[0];
                        r_count <= shift;
                        if (operation[1]) begin
                            r_state    <= c_DONE;
                            done       <= 1'b1;
                            out        <= in;
                            status_new <= status_old;
                        end else begin
                            r_state <= c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    r_acc   <= w_next_acc;
                    r_carry <= w_next_c;
                    if (w_do_step) begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                    if (w_last) begin
                        r_state    <= c_DONE;
                        done       <= 1'b1;
                        out        <= w_next_acc;
                        status_new <= {r_v, w_next_acc[WORD-1], ~|w_next_acc, w_next_c};
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
